// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring; registered one-hot grant held until release.
// Optional per-winner hold limit enabled by defining RR_HOLD_LIMIT_EN.
module ring_rr_arbiter #(
   parameter  int unsigned N        = 3,
   parameter  int unsigned HOLD_MAX = 4,
   localparam int unsigned IDXW     = $clog2(N)
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [N-1:0]    Req,
   output logic [N-1:0]    Grant,
   output logic            Grant_valid,
   output logic [IDXW-1:0] Grant_idx
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      ptr, ptr_d;
   logic [N-1:0]      grant_d;
   logic [N-1:0]      ptr_rot;
   logic [N-1:0]      others;
   logic              release_g;
   logic              rotate;

`ifdef RR_HOLD_LIMIT_EN
   localparam int unsigned    HCW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

   logic [HCW-1:0]    hold_cnt, hold_d;
   logic              force_rot;
`endif

   // First set bit of req, searching upward from the one-hot start position with wrap.
   function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [N-1:0] start);
      logic [N-1:0] win;
      logic         found;
      int unsigned  sidx;
      win   = '0;
      found = 1'b0;
      sidx  = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (start[i]) sidx = i;
      end
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && req[(sidx + k) % N]) begin
            win[(sidx + k) % N] = 1'b1;
            found               = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [IDXW-1:0] to_idx(input logic [N-1:0] oh);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (oh[i]) idx = IDXW'(i);
      end
      return idx;
   endfunction

   assign ptr_rot   = {Grant[N-2:0], Grant[N-1]};
   assign others    = Req & ~Grant;
   assign release_g = ~|(Req & Grant);

`ifdef RR_HOLD_LIMIT_EN
   assign force_rot = (hold_cnt == HOLD_LAST) && (|others);
   assign rotate    = release_g | force_rot;
`else
   assign rotate    = release_g;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr;
      grant_d = Grant;
`ifdef RR_HOLD_LIMIT_EN
      hold_d  = hold_cnt;
`endif
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (|Req) begin
               grant_d = pick(Req, ptr);
               state_d = S_GRANT;
`ifdef RR_HOLD_LIMIT_EN
               hold_d  = '0;
`endif
            end
         end
         S_GRANT: begin
            if (rotate) begin
               // Release and forced rotation share one path: the ring advances past the
               // current winner and any other waiting requester is granted at the same edge.
               ptr_d = ptr_rot;
`ifdef RR_HOLD_LIMIT_EN
               hold_d = '0;
`endif
               if (|others) begin
                  grant_d = pick(others, ptr_rot);
               end else begin
                  grant_d = '0;
                  state_d = S_IDLE;
               end
            end
`ifdef RR_HOLD_LIMIT_EN
            else if (hold_cnt != HOLD_LAST) begin
               hold_d = hold_cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         ptr         <= {{(N-1){1'b0}}, 1'b1};
         Grant       <= '0;
         Grant_valid <= 1'b0;
         Grant_idx   <= '0;
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr         <= ptr_d;
         Grant       <= grant_d;
         Grant_valid <= |grant_d;
         Grant_idx   <= to_idx(grant_d);
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt    <= hold_d;
`endif
      end
   end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios plus randomized traffic against an index-level model.
module tb_ring_rr_arbiter;

   localparam int unsigned N        = 3;
   localparam int unsigned HOLD_MAX = 4;

   logic         Clock = 1'b0;
   logic         Reset = 1'b1;
   logic [N-1:0] Req   = '0;
   logic [N-1:0] Grant;
   logic         Grant_valid;
   logic [1:0]   Grant_idx;

   int checks = 0;
   int errors = 0;

   // Model state: winner index (-1 when idle), priority index, cycles held beyond the first.
   int m_win = -1;
   int m_ptr = 0;
   int m_hc  = 0;

   always #5 Clock = ~Clock;

   ring_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Req         (Req),
      .Grant       (Grant),
      .Grant_valid (Grant_valid),
      .Grant_idx   (Grant_idx)
   );

   function automatic int first_from(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic rst, input logic [N-1:0] r);
      logic [N-1:0] rest;
      bit           limit;
      if (rst) begin
         m_win = -1;
         m_ptr = 0;
         m_hc  = 0;
      end else if (m_win < 0) begin
         m_win = first_from(r, m_ptr);
         m_hc  = 0;
      end else begin
         rest        = r;
         rest[m_win] = 1'b0;
         limit       = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
         limit = (m_hc == HOLD_MAX - 1) && (rest != 0);
`endif
         if (!r[m_win] || limit) begin
            m_ptr = (m_win + 1) % N;
            m_win = first_from(rest, m_ptr);
            m_hc  = 0;
         end else if (m_hc < HOLD_MAX - 1) begin
            m_hc++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] exp_g;
      logic [N-1:0] exp_p;
      exp_g = '0;
      if (m_win >= 0) exp_g[m_win] = 1'b1;
      exp_p = '0;
      exp_p[m_ptr] = 1'b1;
      check({tag, "_grant"}, 64'(Grant), 64'(exp_g));
      check({tag, "_valid"}, 64'(Grant_valid), 64'(m_win >= 0));
      check({tag, "_idx"}, 64'(Grant_idx), (m_win >= 0) ? 64'(m_win) : 64'd0);
      check({tag, "_ptr"}, 64'(dut.ptr), 64'(exp_p));
      check({tag, "_onehot0"}, 64'($onehot0(Grant)), 64'd1);
   endtask

   task automatic step(input string tag, input logic rst, input logic [N-1:0] r);
      @(negedge Clock);
      Reset = rst;
      Req   = r;
      @(posedge Clock);
      model_edge(rst, r);
      #1;
      check_model(tag);
   endtask

   logic [N-1:0] seq_req [7];
   logic [N-1:0] seq_g   [7];
   logic [N-1:0] rnd_req;
   logic         rnd_rst;

   initial begin
      // Test 1: reset held with all requests high
      step("t1a", 1'b1, 3'b111);
      step("t1b", 1'b1, 3'b111);
      check("t1_grant", 64'(Grant), 64'd0);
      check("t1_ptr", 64'(dut.ptr), 64'b001);

      // Test 2: single requester, 1-cycle latency, release to idle
      for (int i = 0; i < 3; i++) begin
         step("t2h", 1'b0, 3'b001);
         check("t2_grant", 64'(Grant), 64'b001);
         check("t2_idx", 64'(Grant_idx), 64'd0);
      end
      step("t2r", 1'b0, 3'b000);
      check("t2_idle", 64'(Grant), 64'd0);
      check("t2_valid", 64'(Grant_valid), 64'd0);

      // Test 3: back-to-back rotation through all requesters
      step("t3rst", 1'b1, 3'b000);
      seq_req = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
      seq_g   = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
      for (int i = 0; i < 7; i++) begin
         step("t3", 1'b0, seq_req[i]);
         check("t3_order", 64'(Grant), 64'(seq_g[i]));
      end

      // Test 4: pointer wrap picks the top requester first
      step("t4rst", 1'b1, 3'b000);
      step("t4a", 1'b0, 3'b010);
      check("t4_g010", 64'(Grant), 64'b010);
      step("t4b", 1'b0, 3'b000);
      check("t4_ptr100", 64'(dut.ptr), 64'b100);
      step("t4c", 1'b0, 3'b101);
      check("t4_g100", 64'(Grant), 64'b100);
      check("t4_idx2", 64'(Grant_idx), 64'd2);
      step("t4d", 1'b0, 3'b001);
      check("t4_g001", 64'(Grant), 64'b001);

      // Test 5: constant contention between two requesters
      step("t5rst", 1'b1, 3'b000);
      for (int i = 0; i < 9; i++) begin
         step("t5", 1'b0, 3'b011);
`ifdef RR_HOLD_LIMIT_EN
         check("t5_hold", 64'(Grant), (i >= 4 && i < 8) ? 64'b010 : 64'b001);
`else
         check("t5_hold", 64'(Grant), 64'b001);
`endif
      end

      // Test 6: reset pulse mid-grant
      step("t6rst", 1'b1, 3'b000);
      step("t6a", 1'b0, 3'b010);
      step("t6b", 1'b0, 3'b111);
      check("t6_g010", 64'(Grant), 64'b010);
      step("t6c", 1'b1, 3'b111);
      check("t6_clear", 64'(Grant), 64'd0);
      check("t6_ptr", 64'(dut.ptr), 64'b001);
      step("t6d", 1'b0, 3'b111);
      check("t6_g001", 64'(Grant), 64'b001);

      // Randomized traffic; current winner tends to keep its request to exercise long holds
      for (int i = 0; i < 400; i++) begin
         rnd_rst = ($urandom_range(0, 31) == 0);
         rnd_req = N'($urandom_range(0, 7));
         if (m_win >= 0 && $urandom_range(0, 3) != 0) rnd_req[m_win] = 1'b1;
         step("rnd", rnd_rst, rnd_req);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
